// File: rtl/add_unit.sv
`default_nettype none
// ============================================================================
// Module      : add_unit
// Description : Element-wise matrix adder, out = A + B over an m x n active
//               region of MAX_DIM x MAX_DIM flat row-major buses. Elements
//               are unsigned, the sum wraps modulo 2^ELEM_WIDTH.
//               Elements outside the active region read as zero. Illegal
//               dimensions (0 or > MAX_DIM) force a zero result and valid=0.
// Ports       : clk         in  system clock (used only with output register)
//               reset       in  asynchronous active-high reset
//               m, n        in  active row / column count
//               matrixA_in  in  operand A, element (r,c) at (r*MAX_DIM+c)*EW
//               matrixB_in  in  operand B, same layout
//               matrix_out  out result, same layout
//               valid       out 1 = dimensions legal, result meaningful
// Options     : ADDUNIT_OUTREG_EN - when defined, matrix_out/valid are
//               registered on posedge clk (1-cycle latency). When undefined
//               the block is combinational and reset gates the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module add_unit #(
    parameter int MAX_DIM    = 5,
    parameter int ELEM_WIDTH = 8,
    parameter int DIM_WIDTH  = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [DIM_WIDTH-1:0]                    m,
    input  logic [DIM_WIDTH-1:0]                    n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0]   matrixA_in,
    input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0]   matrixB_in,
    output logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0]   matrix_out,
    output logic                                    valid
);

    localparam int                 c_bus_width = MAX_DIM*MAX_DIM*ELEM_WIDTH;
    // One extra bit so MAX_DIM itself is representable even when it equals
    // 2^DIM_WIDTH; m/n are zero-extended to this width before comparing.
    localparam logic [DIM_WIDTH:0] c_max_dim   = (DIM_WIDTH+1)'(MAX_DIM);

    logic [DIM_WIDTH:0]   w_m_ext;
    logic [DIM_WIDTH:0]   w_n_ext;
    logic                 w_legal;
    logic [c_bus_width-1:0] w_result;

    assign w_m_ext = {1'b0, m};
    assign w_n_ext = {1'b0, n};
    assign w_legal = (w_m_ext != '0) && (w_m_ext <= c_max_dim) &&
                     (w_n_ext != '0) && (w_n_ext <= c_max_dim);

    // Row stride is always MAX_DIM, so element placement never depends on n.
    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        localparam logic [DIM_WIDTH:0] c_row = (DIM_WIDTH+1)'(r);
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            localparam logic [DIM_WIDTH:0] c_col = (DIM_WIDTH+1)'(c);
            localparam int                 c_lsb = (r*MAX_DIM + c)*ELEM_WIDTH;

            logic [ELEM_WIDTH-1:0] w_sum;
            logic                  w_active;

            // Carry out of the element width is intentionally dropped.
            assign w_sum    = matrixA_in[c_lsb +: ELEM_WIDTH] +
                              matrixB_in[c_lsb +: ELEM_WIDTH];
            assign w_active = w_legal && (c_row < w_m_ext) && (c_col < w_n_ext);
            assign w_result[c_lsb +: ELEM_WIDTH] = w_active ? w_sum : '0;
        end
    end

`ifdef ADDUNIT_OUTREG_EN
    logic [c_bus_width-1:0] r_matrix_out;
    logic                   r_valid;

    // Loads every cycle; no enable or stall path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_matrix_out <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_matrix_out <= w_result;
            r_valid      <= w_legal;
        end
    end

    assign matrix_out = r_matrix_out;
    assign valid      = r_valid;
`else
    // clk has no role in the combinational build.
    logic w_unused_clk;
    assign w_unused_clk = clk;

    // Reset forces the outputs low without any storage.
    assign matrix_out = reset ? '0   : w_result;
    assign valid      = reset ? 1'b0 : w_legal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_unit.sv
`timescale 1ns/1ps
module tb_add_unit;

    localparam int MD  = 5;
    localparam int EW  = 8;
    localparam int DW  = 3;
    localparam int BUS = MD*MD*EW;

    logic           clk = 1'b0;
    logic           reset;
    logic [DW-1:0]  m;
    logic [DW-1:0]  n;
    logic [BUS-1:0] a_in;
    logic [BUS-1:0] b_in;
    logic [BUS-1:0] out;
    logic           valid;

    int tests_run = 0;
    int tests_failed = 0;

    add_unit #(.MAX_DIM(MD), .ELEM_WIDTH(EW), .DIM_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .m          (m),
        .n          (n),
        .matrixA_in (a_in),
        .matrixB_in (b_in),
        .matrix_out (out),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit model_valid(input int mm, input int nn);
        return (mm >= 1) && (mm <= MD) && (nn >= 1) && (nn <= MD);
    endfunction

    function automatic logic [BUS-1:0] model_out(input int mm, input int nn,
                                                 input logic [BUS-1:0] a,
                                                 input logic [BUS-1:0] b);
        logic [BUS-1:0] res;
        int s;
        res = '0;
        if (!model_valid(mm, nn)) return res;
        for (int r = 0; r < mm; r++)
            for (int c = 0; c < nn; c++) begin
                s = (int'(a[(r*MD+c)*EW +: EW]) + int'(b[(r*MD+c)*EW +: EW])) % 256;
                res[(r*MD+c)*EW +: EW] = 8'(s);
            end
        return res;
    endfunction

    function automatic logic [EW-1:0] elem(input logic [BUS-1:0] bus, input int r, input int c);
        return bus[(r*MD+c)*EW +: EW];
    endfunction

    task automatic set_elem(inout logic [BUS-1:0] bus, input int r, input int c, input int v);
        bus[(r*MD+c)*EW +: EW] = 8'(v);
    endtask

    // ---------------- checkers ----------------
    task automatic check_bus(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic [BUS-1:0] snap_out = '0;
    logic           snap_valid = 1'b0;

    // Value the output register should capture at each edge.
    always @(posedge clk) begin
        snap_out   = reset ? '0 : model_out(int'(m), int'(n), a_in, b_in);
        snap_valid = reset ? 1'b0 : model_valid(int'(m), int'(n));
    end

    always @(negedge clk) begin
        logic [BUS-1:0] e_out;
        logic           e_valid;
`ifdef ADDUNIT_OUTREG_EN
        e_out   = reset ? '0 : snap_out;
        e_valid = reset ? 1'b0 : snap_valid;
`else
        e_out   = reset ? '0 : model_out(int'(m), int'(n), a_in, b_in);
        e_valid = reset ? 1'b0 : model_valid(int'(m), int'(n));
`endif
        check_bus("cyc_out", out, e_out);
        check_bit("cyc_valid", valid, e_valid);
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply(input int mm, input int nn, input logic [BUS-1:0] a, input logic [BUS-1:0] b);
        @(posedge clk); #1;
        m = DW'(mm); n = DW'(nn); a_in = a; b_in = b;
    endtask

    task automatic settle();
`ifdef ADDUNIT_OUTREG_EN
        @(posedge clk);
`endif
        @(negedge clk);
    endtask

    function automatic logic [BUS-1:0] rand_bus();
        logic [BUS-1:0] v;
        for (int i = 0; i < BUS/8; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    logic [BUS-1:0] ta, tb, te;

    initial begin
        reset = 1'b1; m = '0; n = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bus("reset_out", out, '0);
        check_bit("reset_valid", valid, 1'b0);
        reset = 1'b0;

        // Scenario 1: 2x3
        ta = '0; tb = '0;
        set_elem(ta,0,0,1); set_elem(ta,0,1,2); set_elem(ta,0,2,3);
        set_elem(ta,1,0,3); set_elem(ta,1,1,4); set_elem(ta,1,2,5);
        for (int c = 0; c < 3; c++) begin set_elem(tb,0,c,3); set_elem(tb,1,c,2); end
        apply(2, 3, ta, tb);
        settle();
        te = '0;
        set_elem(te,0,0,4); set_elem(te,0,1,5); set_elem(te,0,2,6);
        set_elem(te,1,0,5); set_elem(te,1,1,6); set_elem(te,1,2,7);
        check_bus("sc1_out", out, te);
        check_bus("sc1_model", model_out(2, 3, ta, tb), te);
        check_bit("sc1_valid", valid, 1'b1);

        // Scenario 2: wrap
        ta = '0; tb = '0; set_elem(ta,0,0,200); set_elem(tb,0,0,100);
        apply(1, 1, ta, tb);
        settle();
        check_val("sc2_wrap", int'(elem(out,0,0)), 44);
        check_bit("sc2_valid", valid, 1'b1);

        // Scenario 3: full 5x5
        ta = '0; tb = '0;
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) begin
            set_elem(ta,r,c,r*5+c); set_elem(tb,r,c,10);
        end
        apply(5, 5, ta, tb);
        settle();
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++)
            check_val($sformatf("sc3_e%0d%0d", r, c), int'(elem(out,r,c)), r*5+c+10);

        // Scenario 4: data outside active region ignored
        ta = '0; tb = '0;
        set_elem(ta,0,0,11); set_elem(ta,1,1,20); set_elem(tb,0,1,5); set_elem(tb,1,0,6);
        set_elem(ta,4,4,9); set_elem(tb,0,4,7);
        apply(2, 2, ta, tb);
        settle();
        check_val("sc4_e44", int'(elem(out,4,4)), 0);
        check_val("sc4_e04", int'(elem(out,0,4)), 0);
        check_val("sc4_e00", int'(elem(out,0,0)), 11);
        check_val("sc4_e01", int'(elem(out,0,1)), 5);
        check_val("sc4_e10", int'(elem(out,1,0)), 6);
        check_val("sc4_e11", int'(elem(out,1,1)), 20);

        // Scenario 5: illegal dims
        ta = rand_bus() | {(BUS/8){8'h01}}; tb = rand_bus() | {(BUS/8){8'h01}};
        apply(0, 3, ta, tb); settle();
        check_bus("sc5_m0_out", out, '0); check_bit("sc5_m0_valid", valid, 1'b0);
        apply(6, 3, ta, tb); settle();
        check_bus("sc5_m6_out", out, '0); check_bit("sc5_m6_valid", valid, 1'b0);
        apply(3, 7, ta, tb); settle();
        check_bus("sc5_n7_out", out, '0); check_bit("sc5_n7_valid", valid, 1'b0);
        apply(3, 0, ta, tb); settle();
        check_bit("sc5_n0_valid", valid, 1'b0);

        // Scenario 6: reset with scenario-1 inputs
        ta = '0; tb = '0;
        set_elem(ta,0,0,1); set_elem(ta,0,1,2); set_elem(ta,0,2,3);
        set_elem(ta,1,0,3); set_elem(ta,1,1,4); set_elem(ta,1,2,5);
        for (int c = 0; c < 3; c++) begin set_elem(tb,0,c,3); set_elem(tb,1,c,2); end
        apply(2, 3, ta, tb);
        settle();
        #1 reset = 1'b1;
        #1;
        check_bus("sc6_rst_out", out, '0);
        check_bit("sc6_rst_valid", valid, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        #1;
`ifdef ADDUNIT_OUTREG_EN
        check_bus("sc6_hold_out", out, '0);
        check_bit("sc6_hold_valid", valid, 1'b0);
        @(posedge clk); #1;
`endif
        check_bus("sc6_out", out, te);
        check_bit("sc6_valid", valid, 1'b1);

        // Random traffic with occasional reset pulses
        repeat (400) begin
            int mm, nn;
            mm = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 7));
            nn = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 7));
            @(posedge clk); #1;
            reset = ($urandom_range(0, 19) == 0);
            m = DW'(mm); n = DW'(nn); a_in = rand_bus(); b_in = rand_bus();
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
